// File: rtl/axis_defines.sv
// Shared axis stream defines. Holds the axis write-stream width so every
// block that attaches to the axis write port agrees on it.
`ifndef AXIS_DEFINES_SV
`define AXIS_DEFINES_SV
`define AXIS_STREAM_WIDTH 32
`endif

// File: rtl/axis_pack.sv
// axis_pack: packs narrow IN_WIDTH samples into STREAM_WIDTH words for the
// axis write stream. Samples fill lanes from lane 0 upward; a word is closed
// when the top lane is written or when in_last arrives early. An early-closed
// word carries zeros in the unused upper lanes and is flagged by out_padded.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   input sample valid
//   in_data    input sample (IN_WIDTH)
//   in_last    final sample of a frame, sampled on accepted beats only
//   in_ready   sample accepted when in_valid is also high
//   out_valid  packed word valid (axis wr_valid)
//   out_data   packed word (axis wr_data, STREAM_WIDTH)
//   out_ready  axis wr_ready
//   out_padded current out_data was closed early by in_last
//   word_cnt   number of words transferred on the output (wraps)
`ifndef AXIS_DEFINES_SV
`include "axis_defines.sv"
`endif

module axis_pack #(
    parameter int IN_WIDTH     = 8,
    parameter int STREAM_WIDTH = `AXIS_STREAM_WIDTH,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [IN_WIDTH-1:0]     in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [STREAM_WIDTH-1:0] out_data,
    input  logic                    out_ready,
    output logic                    out_padded,
    output logic [CNT_WIDTH-1:0]    word_cnt
);

    localparam int RATIO = STREAM_WIDTH / IN_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((STREAM_WIDTH % IN_WIDTH) != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_ratio_chk
        $error("axis_pack: STREAM_WIDTH/IN_WIDTH must be a power of two >= 2");
    end

    logic [IDX_W-1:0]        idx;
    logic [STREAM_WIDTH-1:0] asm_q;
    logic [STREAM_WIDTH-1:0] asm_next;
    logic                    accept;
    logic                    xfer;
    logic                    last_lane;
    logic                    complete;

    // The output register is the only buffer, so a new sample can only be
    // taken when that register is empty or draining this cycle.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign last_lane = (idx == IDX_W'(RATIO - 1));
    assign complete  = accept && (last_lane || in_last);

    // Lanes above idx are always zero in asm_q (cleared on every completion
    // and filled strictly in order), so merging the current sample here
    // yields a correctly zero-padded word on an early close.
    always_comb begin
        asm_next = asm_q;
        asm_next[int'(idx)*IN_WIDTH +: IN_WIDTH] = in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (complete) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (accept) begin
            idx   <= idx + IDX_W'(1);
            asm_q <= asm_next;
        end
    end

    // A completion in the same cycle as a transfer reloads the register
    // directly, so back-to-back words leave no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_padded <= 1'b0;
        end else if (complete) begin
            out_valid  <= 1'b1;
            out_data   <= asm_next;
            out_padded <= in_last && !last_lane;
        end else if (xfer) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            word_cnt <= '0;
        else if (xfer)
            word_cnt <= word_cnt + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_axis_pack.sv
module tb_axis_pack;
    localparam int IW = 8;
    localparam int SW = 32;
    localparam int CW = 4;
    localparam int RATIO = SW / IW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [SW-1:0] out_data;
    logic          out_ready = 1'b1;
    logic          out_padded;
    logic [CW-1:0] word_cnt;

    int checks = 0;
    int errors = 0;

    axis_pack #(.IN_WIDTH(IW), .STREAM_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_padded(out_padded), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending samples collect in a queue; a word forms when
    // RATIO samples are held or in_last arrives.
    logic [IW-1:0] cur[$];
    logic          exp_valid;
    logic [SW-1:0] exp_data;
    logic          exp_pad;
    int            exp_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur.delete();
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_pad   = 1'b0;
            exp_cnt   = 0;
        end else begin
            bit acc, xf;
            xf  = exp_valid && out_ready;
            acc = in_valid && (!exp_valid || out_ready);
            if (xf) exp_cnt = (exp_cnt + 1) % (1 << CW);
            if (xf) exp_valid = 1'b0;
            if (acc) begin
                cur.push_back(in_data);
                if (cur.size() == RATIO || in_last) begin
                    logic [SW-1:0] w;
                    w = '0;
                    foreach (cur[i]) w = w | (SW'(cur[i]) << (i * IW));
                    exp_valid = 1'b1;
                    exp_data  = w;
                    exp_pad   = (cur.size() < RATIO);
                    cur.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready", 64'(in_ready), 64'(!exp_valid || out_ready));
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            chk("word_cnt", 64'(word_cnt), 64'(exp_cnt));
            if (exp_valid) begin
                chk("out_data", 64'(out_data), 64'(exp_data));
                chk("out_padded", 64'(out_padded), 64'(exp_pad));
            end
        end
    end

    // Record every transferred word for literal checks.
    logic [SW:0] got[$];
    always @(posedge clk)
        if (rst && out_valid && out_ready) got.push_back({out_padded, out_data});

    bit stalled;

    task automatic send(input logic [IW-1:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            stalled = 1'b1;
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready stuck 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        // Reset state
        #2;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_out_padded", 64'(out_padded), 0);
        chk("rst_word_cnt", 64'(word_cnt), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("ready_after_rst", 64'(in_ready), 1);

        // Full word
        got.delete();
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        chk("full_valid", 64'(out_valid), 1);
        chk("full_data", 64'(out_data), 64'h44332211);
        chk("full_pad", 64'(out_padded), 0);
        tick();
        chk("full_cnt", 64'(word_cnt), 1);
        chk("full_valid_clr", 64'(out_valid), 0);

        // Early close, next sample in lane 0
        got.delete();
        send(8'hAA, 0); send(8'hBB, 1);
        send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
        tick();
        chk("pad_n", 64'(got.size()), 2);
        if (got.size() == 2) begin
            chk("pad_word", 64'(got[0]), {31'd0, 1'b1, 32'h0000BBAA});
            chk("pad_next", 64'(got[1]), {31'd0, 1'b0, 32'hC4C3C2C1});
        end

        // in_last on top lane: full word, not padded
        got.delete();
        send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 1);
        tick();
        if (got.size() == 1) chk("last_top", 64'(got[0]), {31'd0, 1'b0, 32'h08070605});
        else chk("last_top_n", 64'(got.size()), 1);

        // Back-to-back, no bubble
        got.delete();
        stalled = 1'b0;
        for (int i = 1; i <= 8; i++) send(IW'(i), 0);
        tick();
        chk("b2b_stall", 64'(stalled), 0);
        chk("b2b_n", 64'(got.size()), 2);
        if (got.size() == 2) begin
            chk("b2b_w0", 64'(got[0]), {31'd0, 1'b0, 32'h04030201});
            chk("b2b_w1", 64'(got[1]), {31'd0, 1'b0, 32'h08070605});
        end

        // Backpressure for 5 cycles
        out_ready = 1'b0;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        c0 = int'(word_cnt);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", 64'(in_ready), 0);
            chk("bp_data", 64'(out_data), 64'h44332211);
            chk("bp_valid", 64'(out_valid), 1);
        end
        tick();
        out_ready = 1'b1;
        tick();
        chk("bp_cnt", 64'(word_cnt), 64'((c0 + 1) % 16));
        chk("bp_valid_clr", 64'(out_valid), 0);

        // Reset mid-word
        send(8'h99, 0); send(8'h98, 0);
        rst = 1'b0;
        #2;
        chk("mid_rst_valid", 64'(out_valid), 0);
        chk("mid_rst_cnt", 64'(word_cnt), 0);
        tick();
        rst = 1'b1;
        got.delete();
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        tick();
        if (got.size() == 1) chk("mid_rst_word", 64'(got[0]), {31'd0, 1'b0, 32'h44332211});
        else chk("mid_rst_n", 64'(got.size()), 1);
        chk("mid_rst_cnt1", 64'(word_cnt), 1);

        // Counter wrap: 17 words on a 4-bit counter
        rst = 1'b0;
        tick();
        rst = 1'b1;
        got.delete();
        for (int w = 0; w < 17; w++)
            for (int s = 0; s < RATIO; s++) send(IW'(w * 4 + s), 0);
        tick();
        chk("wrap_n", 64'(got.size()), 17);
        chk("wrap_cnt", 64'(word_cnt), 1);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
